// File: rtl/aes_req_ctrl.sv
// aes_req_ctrl: request/response sequencer for one AES core.
// Captures a request, pulses core_ld once, waits for core_done (bounded by
// a timeout) and queues the result or a timeout error in an output FIFO.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; in_ready when the FIFO has room
// ST_LOAD | core_ld asserted for this single cycle, timer armed
// ST_BUSY | waiting for core_done; push result or timeout error
module aes_req_ctrl #(
   parameter int KEY_W      = 128,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_mode,
   input  logic [KEY_W-1:0]                  in_key,
   input  logic [127:0]                      in_text,
   input  logic [TAG_W-1:0]                  in_tag,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [127:0]                      out_text,
   output logic [TAG_W-1:0]                  out_tag,
   output logic                              out_mode,
   output logic                              out_err,
   output logic                              core_ld,
   output logic                              core_mode,
   output logic [KEY_W-1:0]                  core_key,
   output logic [127:0]                      core_text_in,
   input  logic                              core_done,
   input  logic [127:0]                      core_text_out,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic [7:0]                        err_count
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   // Down-counter terminal count at zero gives exactly TIMEOUT BUSY cycles.
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_BUSY
   } state_t;

   state_t             state_q, state_d;
   logic               accept;
   logic               push, push_err, pop;
   logic [127:0]       push_text;
   logic [TW-1:0]      timer_q;

   logic               cap_mode;
   logic [KEY_W-1:0]   cap_key;
   logic [127:0]       cap_text;
   logic [TAG_W-1:0]   cap_tag;

   logic [127:0]       mem_text [FIFO_DEPTH];
   logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];
   logic               mem_mode [FIFO_DEPTH];
   logic               mem_err  [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [LW-1:0]      level_q;

   // in_ready is held low during reset so nothing is accepted while rst=0.
   assign in_ready = rst && (state_q == ST_IDLE) && (level_q < LVL_FULL);
   assign accept   = in_valid && in_ready;
   assign out_valid = (level_q != '0);
   assign pop      = out_valid && out_ready;
   assign busy     = (state_q != ST_IDLE);
   assign fifo_level = level_q;

   assign core_mode    = cap_mode;
   assign core_key     = cap_key;
   assign core_text_in = cap_text;

   // Empty FIFO shows zeros so stale entries never leak onto out_*.
   assign out_text = out_valid ? mem_text[rd_ptr] : '0;
   assign out_tag  = out_valid ? mem_tag[rd_ptr]  : '0;
   assign out_mode = out_valid ? mem_mode[rd_ptr] : 1'b0;
   assign out_err  = out_valid ? mem_err[rd_ptr]  : 1'b0;

   assign push_text = push_err ? 128'h0 : core_text_out;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and control strobes; core_done wins over the timeout.
   always_comb begin
      state_d  = state_q;
      core_ld  = 1'b0;
      push     = 1'b0;
      push_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            core_ld = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (core_done) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else if (timer_q == '0) begin
               push     = 1'b1;
               push_err = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request capture; held stable from LOAD through BUSY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_mode <= 1'b0;
         cap_key  <= '0;
         cap_text <= '0;
         cap_tag  <= '0;
      end else if (accept) begin
         cap_mode <= in_mode;
         cap_key  <= in_key;
         cap_text <= in_text;
         cap_tag  <= in_tag;
      end
   end

   // Timeout down-counter, armed in LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                      timer_q <= '0;
      else if (state_q == ST_LOAD)                   timer_q <= TMR_LOAD;
      else if (state_q == ST_BUSY && timer_q != '0)  timer_q <= timer_q - 1'b1;
   end

   // Saturating timeout counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     err_count <= 8'd0;
      else if (push && push_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
   end

   // FIFO storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_text[wr_ptr] <= push_text;
         mem_tag[wr_ptr]  <= cap_tag;
         mem_mode[wr_ptr] <= cap_mode;
         mem_err[wr_ptr]  <= push_err;
      end
   end

   // FIFO pointers and occupancy; power-of-2 depth wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_req_ctrl.sv
// Bench for aes_req_ctrl: a stub AES core with programmable latency, a
// result scoreboard fed at accept time, directed scenarios and a random run.
module tb_aes_req_ctrl;

   localparam int KEY_W = 128;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0, in_ready, in_mode = 1'b0;
   logic [KEY_W-1:0]   in_key = '0;
   logic [127:0]       in_text = '0;
   logic [TAG_W-1:0]   in_tag = '0;
   logic               out_valid, out_ready = 1'b0;
   logic [127:0]       out_text;
   logic [TAG_W-1:0]   out_tag;
   logic               out_mode, out_err;
   logic               core_ld, core_mode;
   logic [KEY_W-1:0]   core_key;
   logic [127:0]       core_text_in;
   logic               core_done = 1'b0;
   logic [127:0]       core_text_out = '0;
   logic               busy;
   logic [$clog2(DEPTH+1)-1:0] fifo_level;
   logic [7:0]         err_count;

   aes_req_ctrl #(.KEY_W(KEY_W), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_key(in_key), .in_text(in_text), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
      .out_tag(out_tag), .out_mode(out_mode), .out_err(out_err),
      .core_ld(core_ld), .core_mode(core_mode), .core_key(core_key),
      .core_text_in(core_text_in), .core_done(core_done),
      .core_text_out(core_text_out),
      .busy(busy), .fifo_level(fifo_level), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0]     text;
      logic [TAG_W-1:0] tag;
      logic             mode;
      logic             err;
   } res_t;

   res_t exp_q[$];
   int   lat_q[$];
   int   n_checks = 0, n_errors = 0;
   int   lat_cur = 1;
   int   ld_pulses = 0, accepts = 0, err_model = 0;
   int   core_cnt = 0;
   bit   rand_rdy = 0, spurious = 0;
   res_t mon_e;
   bit   mon_to;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stub core: the known FIPS-197 pair, otherwise a reversible scramble.
   function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k,
                                            input logic [127:0] t);
      if (!m && k == K0 && t == P0) return C0;
      if (m && k == K0 && t == C0) return P0;
      return t ^ k ^ (m ? {4{32'hA5C3_0F96}} : 128'h0);
   endfunction

   // Core model: done arrives lat cycles after the ld cycle (lat=0: never).
   initial begin
      forever begin
         @(posedge clk); #1;
         core_done = 1'b0;
         if (!rst) begin
            core_cnt = 0;
         end else if (core_ld) begin
            ld_pulses++;
            chk("ld_has_accept", lat_q.size() != 0, 1);
            core_cnt = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
         end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_done     = 1'b1;
               core_text_out = core_fn(core_mode, core_key, core_text_in);
            end
         end else if (spurious && !busy && $urandom_range(0, 3) == 0) begin
            core_done     = 1'b1;
            core_text_out = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Scoreboard: expected result fixed at accept, compared at pop.
   initial begin
      forever begin
         @(posedge clk); #6;
         if (in_valid && in_ready) begin
            mon_to      = (lat_cur == 0 || lat_cur > TMO);
            mon_e.text  = mon_to ? 128'h0 : core_fn(in_mode, in_key, in_text);
            mon_e.tag   = in_tag;
            mon_e.mode  = in_mode;
            mon_e.err   = mon_to;
            exp_q.push_back(mon_e);
            lat_q.push_back(lat_cur);
            accepts++;
            if (mon_to && err_model < 255) err_model++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_text", out_text, mon_e.text);
               chk("out_tag",  out_tag,  mon_e.tag);
               chk("out_mode", out_mode, mon_e.mode);
               chk("out_err",  out_err,  mon_e.err);
            end
         end
      end
   end

   // Random consumer back-pressure.
   initial begin
      forever begin
         @(posedge clk); #2;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic m, input logic [127:0] k, input logic [127:0] t,
                       input logic [TAG_W-1:0] g, input int lat);
      bit ok = 0;
      @(posedge clk); #2;
      in_valid = 1'b1; in_mode = m; in_key = k; in_text = t; in_tag = g; lat_cur = lat;
      for (int i = 0; i < 400; i++) begin
         #2;
         if (in_ready) begin ok = 1; break; end
         @(posedge clk); #2;
      end
      chk("accept", ok, 1);
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int exp_n, input string tag);
      int n = 0;
      for (int i = 1; i <= 200; i++) begin
         #2;
         n = i;
         if (out_valid) break;
         @(posedge clk); #2;
      end
      chk(tag, n, exp_n);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #4;
         if (!busy) begin ok = 1; break; end
      end
      chk("idle_wait", ok, 1);
   endtask

   task automatic drain();
      bit ok = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #4;
         if (exp_q.size() == 0 && !out_valid && !busy) begin ok = 1; break; end
      end
      chk("drain", ok, 1);
      chk("drain_level", fifo_level, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_busy"},      busy, 0);
      chk({tag, "_level"},     fifo_level, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_core_ld"},   core_ld, 0);
      chk({tag, "_core_key"},  core_key, 0);
      chk({tag, "_core_text"}, core_text_in, 0);
      chk({tag, "_out_text"},  out_text, 0);
   endtask

   initial begin
      int ldp;
      bit seen;
      #1;
      chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // Known-answer encrypt then decrypt.
      out_ready = 1'b0;
      ldp = ld_pulses;
      send(1'b0, K0, P0, 4'd3, 5);
      wait_valid(7, "enc_latency");
      chk("enc_text", out_text, C0);
      chk("enc_tag", out_tag, 3);
      chk("enc_err", out_err, 0);
      chk("enc_ld_pulses", ld_pulses - ldp, 1);
      drain();
      send(1'b1, K0, C0, 4'd5, 3);
      wait_valid(5, "dec_latency");
      chk("dec_text", out_text, P0);
      chk("dec_mode", out_mode, 1);
      drain();

      // Consumer stall: four fill the FIFO, the fifth waits for a pop.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 4'(i), $urandom_range(1, 6));
      wait_idle();
      chk("full_level", fifo_level, 4);
      chk("full_in_ready", in_ready, 0);
      fork
         send(1'b0, {$urandom, $urandom, $urandom, $urandom}, P0, 4'd4, 2);
         begin
            repeat (4) begin
               @(posedge clk); #4;
               chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk); #2;
            out_ready = 1'b1;
         end
      join
      drain();

      // Timeout, done on the final BUSY cycle, done one cycle too late.
      out_ready = 1'b0;
      send(1'b0, K0, P0, 4'd7, 0);
      wait_valid(TMO + 2, "timeout_latency");
      chk("timeout_err", out_err, 1);
      chk("timeout_text", out_text, 0);
      chk("timeout_count", err_count, 1);
      drain();
      out_ready = 1'b0;
      send(1'b1, K0, C0, 4'd8, TMO);
      wait_valid(TMO + 2, "last_cycle_latency");
      chk("last_cycle_err", out_err, 0);
      chk("last_cycle_text", out_text, P0);
      drain();
      out_ready = 1'b0;
      send(1'b0, K0, P0, 4'd9, TMO + 1);
      wait_valid(TMO + 2, "late_done_latency");
      chk("late_done_err", out_err, 1);
      chk("late_done_count", err_count, 2);
      drain();

      // Simultaneous push and pop at level 2.
      out_ready = 1'b0;
      send(1'b0, {$urandom, $urandom, $urandom, $urandom}, P0, 4'd1, 2);
      send(1'b1, {$urandom, $urandom, $urandom, $urandom}, P0, 4'd2, 2);
      wait_idle();
      chk("pp_level_before", fifo_level, 2);
      send(1'b0, {$urandom, $urandom, $urandom, $urandom}, C0, 4'd3, 4);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #3;
         if (core_done) begin seen = 1; break; end
      end
      chk("pp_done_seen", seen, 1);
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
      #2;
      chk("pp_level_after", fifo_level, 2);
      drain();

      // Reset while BUSY with a result already queued.
      out_ready = 1'b0;
      send(1'b0, {$urandom, $urandom, $urandom, $urandom}, P0, 4'd6, 2);
      wait_idle();
      send(1'b0, K0, P0, 4'd7, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("pre_reset_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      exp_q.delete();
      lat_q.delete();
      err_model = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      ldp = ld_pulses;
      repeat (6) @(posedge clk);
      #4;
      chk("no_ld_after_reset", ld_pulses - ldp, 0);
      chk("after_reset_level", fifo_level, 0);
      send(1'b0, K0, P0, 4'd11, 3);
      wait_valid(5, "after_reset_latency");
      chk("after_reset_text", out_text, C0);
      drain();

      // Random traffic with back-pressure and stray core_done in IDLE.
      rand_rdy = 1;
      spurious = 1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 2));
      end
      wait_idle();
      rand_rdy = 0;
      spurious = 0;
      drain();
      chk("rand_err_count", err_count, err_model);

      // Drive err_count into saturation.
      out_ready = 1'b1;
      for (int n = 0; n < 260; n++)
         send(1'b0, {$urandom, $urandom, $urandom, $urandom}, P0, 4'(n), 0);
      drain();
      chk("sat_err_count", err_count, 255);
      chk("sat_err_model", err_count, err_model);
      chk("ld_vs_accepts", ld_pulses, accepts);
      chk("lat_q_empty", lat_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
